mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/scc_pkg.sv | 16 +
 rtl/mem_arbiter.sv | 111 +++++++++++
 2 files changed

// File: rtl/scc_pkg.sv
// Shared SCC definitions: default bus widths, data burst limit and the
// memory response-owner encoding used by the instruction/data arbiter.
package scc_pkg;

   localparam int SCC_ADDR_W      = 32;
   localparam int SCC_DATA_W      = 32;
   localparam int SCC_MAX_D_BURST = 2;

   // Which requester owns the read data returning from memory this cycle.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RESP_IF = 2'd1,
      RESP_D  = 2'd2
   } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a single-port memory with one cycle of read
// latency. Data accesses normally win a collision, but a fetch that is kept
// waiting gets the port after MAX_D_BURST consecutive data grants. Grants are
// combinational; only the response owner, the store flag and the burst count
// are registered, so the read data is steered one cycle after its grant.
module mem_arbiter
   import scc_pkg::*;
#(
   parameter int ADDR_W      = SCC_ADDR_W,
   parameter int DATA_W      = SCC_DATA_W,
   parameter int MAX_D_BURST = SCC_MAX_D_BURST
) (
   input  logic              clk,
   input  logic              reset,
   // fetch requester
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_rdata,
   // data requester
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_valid,
   output logic [DATA_W-1:0] d_rdata,
   // memory port
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   // A zero burst limit still needs a one-bit counter (fetch then always wins).
   localparam int               CNT_W   = (MAX_D_BURST < 1) ? 1 : $clog2(MAX_D_BURST + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_D_BURST);

   owner_e           owner_q, owner_d;
   logic [CNT_W-1:0] burst_q, burst_d;
   logic             we_q, we_d;

   // Arbitration: data wins unless a waiting fetch has seen a full data burst.
   always_comb begin
      d_gnt  = 1'b0;
      if_gnt = 1'b0;
      if (!reset) begin
         d_gnt  = d_req && !(if_req && (burst_q == CNT_MAX));
         if_gnt = if_req && !d_gnt;
      end
   end

   // Memory port is driven straight from the granted requester, zero when idle.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (d_gnt) begin
         mem_en    = 1'b1;
         mem_we    = d_we;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end else if (if_gnt) begin
         mem_en    = 1'b1;
         mem_addr  = if_addr;
      end
   end

   // Next owner follows this cycle's grant; burst count tracks data grants a fetch has sat through.
   always_comb begin
      owner_d = IDLE;
      we_d    = 1'b0;
      burst_d = burst_q;
      if (if_gnt) begin
         owner_d = RESP_IF;
      end else if (d_gnt) begin
         owner_d = RESP_D;
         we_d    = d_we;
      end
      if (if_gnt || !if_req) begin
         burst_d = '0;
      end else if (d_gnt && (burst_q != CNT_MAX)) begin
         burst_d = burst_q + CNT_W'(1);
      end
   end

   // Response-owner state, store flag and burst counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q <= IDLE;
         we_q    <= 1'b0;
         burst_q <= '0;
      end else begin
         owner_q <= owner_d;
         we_q    <= we_d;
         burst_q <= burst_d;
      end
   end

   // Steer returning data to its owner; reset masks a response still in flight.
   always_comb begin
      if_valid = !reset && (owner_q == RESP_IF);
      d_valid  = !reset && (owner_q == RESP_D);
      if_rdata = if_valid ? mem_rdata : '0;
      d_rdata  = (d_valid && !we_q) ? mem_rdata : '0;
   end

endmodule
